// File: rtl/ram32x1s_arbiter.sv
// Two-client round-robin front end for a DATA_W x 32 distributed RAM built from
// 1-bit RAM32X1S-style cells, with a clear sweep after reset or on request.

module ram32x1s_cell (
  input  logic       wclk,
  input  logic       we,
  input  logic [4:0] a,
  input  logic       d,
  output logic       o
);

  logic [31:0] mem;

  always_ff @(posedge wclk) begin
    if (we) mem[a] <= d;
  end

  // Asynchronous read, as in the primitive.
  assign o = mem[a];

endmodule

module ram32x1s_arbiter #(
  parameter int                DATA_W         = 8,
  parameter logic [DATA_W-1:0] CLR_VALUE      = '0,
  parameter logic              CLEAR_ON_RESET = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CLR_REQ,
  output logic              CLR_BUSY,
  input  logic              M0_REQ,
  input  logic              M0_WE,
  input  logic [4:0]        M0_ADDR,
  input  logic [DATA_W-1:0] M0_WDATA,
  output logic              M0_ACK,
  output logic              M0_RVALID,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M1_REQ,
  input  logic              M1_WE,
  input  logic [4:0]        M1_ADDR,
  input  logic [DATA_W-1:0] M1_WDATA,
  output logic              M1_ACK,
  output logic              M1_RVALID,
  output logic [DATA_W-1:0] M1_RDATA,
  output logic              state_dbg
);

  // Handshake: a client raises REQ with WE/ADDR/WDATA stable and holds them until
  // ACK; ACK is a one-cycle combinational grant and the RAM access happens in that
  // cycle. A read returns RVALID with RDATA on the cycle after its ACK.

  typedef enum logic {ST_CLEAR = 1'b0, ST_RUN = 1'b1} state_t;

  state_t            state;
  logic [4:0]        clr_addr;
  logic              rr_last;
  logic              grant0;
  logic              grant1;
  logic              ram_we;
  logic [4:0]        ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  // On contention the requester that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == ST_RUN && !RST) begin
      if (M0_REQ && M1_REQ) begin
        grant0 = rr_last;
        grant1 = !rr_last;
      end else begin
        grant0 = M0_REQ;
        grant1 = M1_REQ;
      end
    end
  end

  always_comb begin
    ram_we   = 1'b0;
    ram_addr = M0_ADDR;
    ram_din  = M0_WDATA;
    if (!RST) begin
      if (state == ST_CLEAR) begin
        ram_we   = 1'b1;
        ram_addr = clr_addr;
        ram_din  = CLR_VALUE;
      end else if (grant1) begin
        ram_we   = M1_WE;
        ram_addr = M1_ADDR;
        ram_din  = M1_WDATA;
      end else if (grant0) begin
        ram_we   = M0_WE;
      end
    end
  end

  assign M0_ACK    = grant0;
  assign M1_ACK    = grant1;
  assign CLR_BUSY  = (state == ST_CLEAR);
  assign state_dbg = state;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
      clr_addr  <= 5'd0;
      rr_last   <= 1'b1;
      M0_RVALID <= 1'b0;
      M1_RVALID <= 1'b0;
      M0_RDATA  <= '0;
      M1_RDATA  <= '0;
    end else begin
      M0_RVALID <= grant0 && !M0_WE;
      M1_RVALID <= grant1 && !M1_WE;
      if (grant0 && !M0_WE) M0_RDATA <= ram_dout;
      if (grant1 && !M1_WE) M1_RDATA <= ram_dout;
      if (M0_REQ && M1_REQ && (grant0 || grant1)) rr_last <= grant1;
      case (state)
        ST_CLEAR: begin
          clr_addr <= clr_addr + 5'd1;
          if (clr_addr == 5'd31) state <= ST_RUN;
        end
        ST_RUN: begin
          if (CLR_REQ) begin
            state    <= ST_CLEAR;
            clr_addr <= 5'd0;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  for (genvar i = 0; i < DATA_W; i++) begin : g_bit
    ram32x1s_cell u_cell (
      .wclk (CLK),
      .we   (ram_we),
      .a    (ram_addr),
      .d    (ram_din[i]),
      .o    (ram_dout[i])
    );
  end

endmodule

// File: tb/tb_ram32x1s_arbiter.sv
// Directed bench for ram32x1s_arbiter: reset sweep, single client, contention,
// clear during traffic, reset during a sweep, and the no-clear-on-reset variant.

module tb_ram32x1s_arbiter;

  logic       clk = 1'b0;
  logic       rst, nc_rst, clr_req;
  logic       m0_req, m0_we, m1_req, m1_we;
  logic [4:0] m0_addr, m1_addr;
  logic [7:0] m0_wdata, m1_wdata;
  logic       clr_busy, m0_ack, m1_ack, m0_rvalid, m1_rvalid, state_dbg;
  logic [7:0] m0_rdata, m1_rdata;
  logic       nc_busy, nc_m0_ack, nc_m1_ack, nc_m0_rvalid, nc_m1_rvalid, nc_state;
  logic [7:0] nc_m0_rdata, nc_m1_rdata;
  logic       nc_busy_seen = 1'b0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (nc_busy) nc_busy_seen = 1'b1;

  ram32x1s_arbiter #(.DATA_W(8), .CLR_VALUE(8'h00), .CLEAR_ON_RESET(1'b1)) dut (
    .CLK(clk), .RST(rst), .CLR_REQ(clr_req), .CLR_BUSY(clr_busy),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_ACK(m0_ack), .M0_RVALID(m0_rvalid), .M0_RDATA(m0_rdata),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_ACK(m1_ack), .M1_RVALID(m1_rvalid), .M1_RDATA(m1_rdata),
    .state_dbg(state_dbg)
  );

  ram32x1s_arbiter #(.DATA_W(8), .CLR_VALUE(8'h00), .CLEAR_ON_RESET(1'b0)) dut_nc (
    .CLK(clk), .RST(nc_rst), .CLR_REQ(clr_req), .CLR_BUSY(nc_busy),
    .M0_REQ(m0_req), .M0_WE(m0_we), .M0_ADDR(m0_addr), .M0_WDATA(m0_wdata),
    .M0_ACK(nc_m0_ack), .M0_RVALID(nc_m0_rvalid), .M0_RDATA(nc_m0_rdata),
    .M1_REQ(m1_req), .M1_WE(m1_we), .M1_ADDR(m1_addr), .M1_WDATA(m1_wdata),
    .M1_ACK(nc_m1_ack), .M1_RVALID(nc_m1_rvalid), .M1_RDATA(nc_m1_rdata),
    .state_dbg(nc_state)
  );

  // One access by client m; returns the ACK seen in the request cycle and the
  // RVALID/RDATA seen in the following cycle.
  task automatic drive_access(input int m, input logic we, input logic [4:0] addr,
                              input logic [7:0] wd, output logic ack,
                              output logic rv, output logic [7:0] rd);
    @(negedge clk);
    if (m == 0) begin
      m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd;
    end else begin
      m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd;
    end
    #1 ack = (m == 0) ? m0_ack : m1_ack;
    @(negedge clk);
    rv = (m == 0) ? m0_rvalid : m1_rvalid;
    rd = (m == 0) ? m0_rdata : m1_rdata;
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    int n;
    logic ack, rv;
    logic [7:0] rd;
    repeat (3) @(posedge clk);
    @(negedge clk);
    m0_req = 1'b1;
    #1;
    total++;
    if (m0_ack !== 1'b0 || clr_busy !== 1'b1 || m0_rvalid !== 1'b0 || m0_rdata !== 8'h00) begin
      bad++;
      $display("FAIL reset_state ack=%b busy=%b rvalid=%b rdata=%h want 0 1 0 00",
               m0_ack, clr_busy, m0_rvalid, m0_rdata);
    end
    m0_req = 1'b0;
    rst = 1'b0;
    #1;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    total++;
    if (n != 32) begin
      bad++;
      $display("FAIL reset_sweep_len busy_cycles=%0d want 32", n);
    end
    for (int a = 0; a < 32; a++) begin
      drive_access(0, 1'b0, 5'(a), 8'h00, ack, rv, rd);
      total++;
      if (ack !== 1'b1 || rv !== 1'b1 || rd !== 8'h00) begin
        bad++;
        $display("FAIL reset_word[%0d] ack=%b rvalid=%b rdata=%h want 1 1 00", a, ack, rv, rd);
      end
    end
  endtask

  task automatic test_single();
    logic ack, rv;
    logic [7:0] rd;
    drive_access(0, 1'b1, 5'd5, 8'hA5, ack, rv, rd);
    total++;
    if (ack !== 1'b1 || rv !== 1'b0) begin
      bad++;
      $display("FAIL single_write ack=%b rvalid=%b want 1 0", ack, rv);
    end
    drive_access(0, 1'b0, 5'd5, 8'h00, ack, rv, rd);
    total++;
    if (ack !== 1'b1 || rv !== 1'b1 || rd !== 8'hA5) begin
      bad++;
      $display("FAIL single_read ack=%b rvalid=%b rdata=%h want 1 1 a5", ack, rv, rd);
    end
  endtask

  task automatic test_contention();
    logic ack, rv;
    logic [7:0] rd;
    drive_access(0, 1'b1, 5'd1, 8'h11, ack, rv, rd);
    drive_access(1, 1'b1, 5'd2, 8'h22, ack, rv, rd);
    @(negedge clk);
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd1;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd2;
    for (int k = 0; k < 7; k++) begin
      #1;
      if (k == 6) begin
        m0_req = 1'b0;
        m1_req = 1'b0;
      end else begin
        total++;
        if (m0_ack !== (k % 2 == 0) || m1_ack !== (k % 2 == 1)) begin
          bad++;
          $display("FAIL contention_ack[%0d] ack0=%b ack1=%b want %b %b",
                   k, m0_ack, m1_ack, (k % 2 == 0), (k % 2 == 1));
        end
      end
      if (k > 0) begin
        total++;
        if ((k - 1) % 2 == 0) begin
          if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m0_rdata !== 8'h11) begin
            bad++;
            $display("FAIL contention_rd[%0d] rv0=%b rv1=%b rd0=%h want 1 0 11",
                     k, m0_rvalid, m1_rvalid, m0_rdata);
          end
        end else begin
          if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0 || m1_rdata !== 8'h22) begin
            bad++;
            $display("FAIL contention_rd[%0d] rv0=%b rv1=%b rd1=%h want 0 1 22",
                     k, m0_rvalid, m1_rvalid, m1_rdata);
          end
        end
      end
      if (k < 6) @(negedge clk);
    end
  endtask

  task automatic test_clear_mid_traffic();
    int n;
    logic ack_seen;
    logic ack, rv;
    logic [7:0] rd;
    drive_access(0, 1'b1, 5'd31, 8'h3C, ack, rv, rd);
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd31;
    clr_req = 1'b1;
    #1;
    total++;
    if (m1_ack !== 1'b1) begin
      bad++;
      $display("FAIL clr_cycle_ack ack1=%b want 1", m1_ack);
    end
    @(negedge clk);
    clr_req = 1'b0;
    #1;
    total++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h3C || clr_busy !== 1'b1) begin
      bad++;
      $display("FAIL clr_cycle_read rv1=%b rd1=%h busy=%b want 1 3c 1", m1_rvalid, m1_rdata, clr_busy);
    end
    n = 0;
    ack_seen = 1'b0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (m0_ack !== 1'b0 || m1_ack !== 1'b0) ack_seen = 1'b1;
      n++;
      @(negedge clk);
      #1;
    end
    total++;
    if (n != 32 || ack_seen !== 1'b0) begin
      bad++;
      $display("FAIL clr_sweep busy_cycles=%0d ack_seen=%b want 32 0", n, ack_seen);
    end
    total++;
    if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin
      bad++;
      $display("FAIL clr_first_grant ack0=%b ack1=%b want 0 1", m0_ack, m1_ack);
    end
    @(negedge clk);
    m1_req = 1'b0;
    total++;
    if (m1_rvalid !== 1'b1 || m1_rdata !== 8'h00) begin
      bad++;
      $display("FAIL clr_readback rv1=%b rd1=%h want 1 00", m1_rvalid, m1_rdata);
    end
  endtask

  task automatic test_reset_mid_sweep();
    int n;
    logic seen;
    logic ack, rv;
    logic [7:0] rd;
    drive_access(0, 1'b1, 5'd5, 8'hA5, ack, rv, rd);
    @(negedge clk);
    clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 5'd5;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (m0_ack !== 1'b0 || m0_rvalid !== 1'b0 || clr_busy !== 1'b1) seen = 1'b1;
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    total++;
    if (clr_busy !== 1'b1 || m0_ack !== 1'b0) begin
      bad++;
      $display("FAIL rst_sweep_during busy=%b ack0=%b want 1 0", clr_busy, m0_ack);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n = 0;
    while (clr_busy === 1'b1 && n < 100) begin
      if (m0_ack !== 1'b0 || m0_rvalid !== 1'b0 || m1_ack !== 1'b0 || m1_rvalid !== 1'b0) seen = 1'b1;
      n++;
      @(negedge clk);
      #1;
    end
    total++;
    if (n != 32 || seen !== 1'b0) begin
      bad++;
      $display("FAIL rst_sweep_restart busy_cycles=%0d ack_or_rvalid_seen=%b want 32 0", n, seen);
    end
    total++;
    if (m0_ack !== 1'b1) begin
      bad++;
      $display("FAIL rst_sweep_grant ack0=%b want 1", m0_ack);
    end
    @(negedge clk);
    m0_req = 1'b0;
    total++;
    if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h00) begin
      bad++;
      $display("FAIL rst_sweep_readback rv0=%b rd0=%h want 1 00", m0_rvalid, m0_rdata);
    end
  endtask

  task automatic test_no_clear_on_reset();
    @(negedge clk);
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 5'd9;
    nc_rst = 1'b0;
    #1;
    total++;
    if (nc_m1_ack !== 1'b1 || nc_busy !== 1'b0) begin
      bad++;
      $display("FAIL nc_first_grant ack1=%b busy=%b want 1 0", nc_m1_ack, nc_busy);
    end
    @(negedge clk);
    m1_req = 1'b0;
    total++;
    if (nc_m1_rvalid !== 1'b1 || nc_m1_rdata !== 8'h00) begin
      bad++;
      $display("FAIL nc_powerup_read rv1=%b rd1=%h want 1 00", nc_m1_rvalid, nc_m1_rdata);
    end
    repeat (3) @(negedge clk);
    total++;
    if (nc_busy_seen !== 1'b0) begin
      bad++;
      $display("FAIL nc_busy_never busy_seen=%b want 0", nc_busy_seen);
    end
  endtask

  initial begin
    rst = 1'b1; nc_rst = 1'b1; clr_req = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    test_reset();
    test_single();
    test_contention();
    test_clear_mid_traffic();
    test_reset_mid_sweep();
    test_no_clear_on_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
